univ_reg_p: RTL
===============

UNIV_REG_P -- requirements
Module: univ_reg_p

Interface
REQ-001 Parameter WIDTH, default 4: register width in bits, legal range 2..32.
REQ-002 Parameter RESET_VALUE, default 0 (WIDTH bits): register contents after reset.
REQ-003 Parameter ROTATE, default 0: 0 selects serial-fill shifting, 1 selects end-around rotation in both shift modes.
REQ-004 Port list: CP in 1, sole clock; register state updates on its rising edge.
REQ-005 Port list: CLRN in 1, reset; synchronous, active-low.
REQ-006 Port list: CE in 1, clock enable, active-high.
REQ-007 Port list: S in 2, mode select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-008 Port list: D in WIDTH, parallel load data.
REQ-009 Port list: SIR in 1, serial input entering the MSB on a right shift.
REQ-010 Port list: SIL in 1, serial input entering the LSB on a left shift.
REQ-011 Port list: Q out WIDTH, register contents.
REQ-012 Port list: QN out WIDTH, bitwise complement of Q at all times.
REQ-013 Port list: SOR out 1, registered copy of the bit shifted out of the LSB on the last right shift.
REQ-014 Port list: SOL out 1, registered copy of the bit shifted out of the MSB on the last left shift.
REQ-015 Port list: ZERO out 1, high when Q equals all-zeros (combinational from Q).

Function
REQ-016 All state changes occur only on rising CP edges; there are no asynchronous paths to state.
REQ-017 CE low: Q, SOR and SOL hold, regardless of S, D and the serial inputs.
REQ-018 CE high, S=00: Q, SOR and SOL hold.
REQ-019 CE high, S=11: Q takes D after one edge, a latency of 1 cycle; SOR and SOL hold.
REQ-020 CE high, S=01, ROTATE=0: Q becomes {SIR, Q[WIDTH-1:1]} and SOR takes the old Q[0]; SOL holds.
REQ-021 CE high, S=10, ROTATE=0: Q becomes {Q[WIDTH-2:0], SIL} and SOL takes the old Q[WIDTH-1]; SOR holds.
REQ-022 ROTATE=1, S=01: Q becomes {Q[0], Q[WIDTH-1:1]}; SIR is ignored and SOR takes the old Q[0].
REQ-023 ROTATE=1, S=10: Q becomes {Q[WIDTH-2:0], Q[WIDTH-1]}; SIL is ignored and SOL takes the old Q[WIDTH-1].
REQ-024 WIDTH shifts in one direction with ROTATE=1 return Q to its starting value (wrap-around).
REQ-025 D, SIR and SIL are sampled only at the active edge; changes between edges have no effect.
REQ-026 QN and ZERO follow Q within the same cycle; there is no extra register stage.

Reset
REQ-027 CLRN low at a rising CP edge: Q becomes RESET_VALUE, QN becomes ~RESET_VALUE, SOR=0, SOL=0.
REQ-028 Reset has priority over CE and over every S mode, including reset asserted in the middle of a shift sequence.
REQ-029 CLRN low between edges has no effect until the next rising CP edge.
REQ-030 The first edge with CLRN high performs the operation selected by CE and S.

Structure
REQ-031 Mode encodings HOLD/SHR/SHL/LOAD (2-bit) belong in shared package ndlib_pkg as named constants.
REQ-032 The block is a single flat module; one sub-module, univ_reg_p_bit (a per-bit 4:1 mux plus flip-flop), is permitted and generated WIDTH times.
REQ-033 The flip-flop storage is the codebase's D_FLIPFLOP-equivalent behaviour, with preset and reset unused; reset is applied through the data path.

Verification
REQ-034 Reset: WIDTH=4, RESET_VALUE=4'hA, CLRN=0 for one edge -> Q=1010, QN=0101, SOR=0, SOL=0, ZERO=0.
REQ-035 Load and hold: S=11, D=4'h5, CE=1, one edge -> Q=0101; then CE=0, S=11, D=4'hF, three edges -> Q=0101.
REQ-036 Shift right fill: Q=0101, S=01, SIR=1, two edges -> Q=1010 after the first edge and SOR=1; Q=1101 after the second edge and SOR=0.
REQ-037 Shift left fill: Q=1001, S=10, SIL=0, one edge -> Q=0010, SOL=1; four more edges -> Q=0000, ZERO=1.
REQ-038 Rotate: ROTATE=1, WIDTH=8, Q=8'h81, S=10, eight edges -> Q=8'h81 after the eighth; after the first edge Q=8'h03 and SOL=1.
REQ-039 Reset priority: during the shift sequence of REQ-036, CLRN=0 with CE=1 and S=01 -> Q=RESET_VALUE on that edge, and shifting resumes on the next edge after CLRN returns high.

Source files
------------

// File: rtl/ndlib_pkg.sv
// Shared mode encodings for the ndlib register blocks.
// Every block that decodes a 2-bit S select imports these names.
package ndlib_pkg;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] SHR  = 2'b01;
  localparam logic [1:0] SHL  = 2'b10;
  localparam logic [1:0] LOAD = 2'b11;

endpackage : ndlib_pkg

// File: rtl/univ_reg_p_bit.sv
// One register bit: a 4:1 mode mux feeding a plain D flip-flop.
// Reset is folded into the mux so the flop itself has no preset/clear.
module univ_reg_p_bit
  import ndlib_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic       ce,
  input  logic [1:0] mode,
  input  logic       loadBit,
  input  logic       shrBit,
  input  logic       shlBit,
  input  logic       resetBit,
  output logic       q
);

  logic nextBit;

  // Next-state select: reset wins, then clock enable, then mode.
  always_comb begin
    nextBit = q;
    if (!clrn) begin
      nextBit = resetBit;
    end else if (ce) begin
      case (mode)
        HOLD:    nextBit = q;
        SHR:     nextBit = shrBit;
        SHL:     nextBit = shlBit;
        LOAD:    nextBit = loadBit;
        default: nextBit = q;
      endcase
    end else begin
      nextBit = q;
    end
  end

  // Storage flop.
  always_ff @(posedge clk) begin
    q <= nextBit;
  end

endmodule : univ_reg_p_bit

// File: rtl/univ_reg_p.sv
// Universal shift register: hold, shift right, shift left, parallel load,
// with serial fill or end-around rotation and registered shift-out bits.
module univ_reg_p
  import ndlib_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter bit               ROTATE      = 1'b0
) (
  input  logic             CP,
  input  logic             CLRN,
  input  logic             CE,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] D,
  input  logic             SIR,
  input  logic             SIL,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SOR,
  output logic             SOL,
  output logic             ZERO
);

  logic             shrIn;
  logic             shlIn;
  logic [WIDTH-1:0] shrVec;
  logic [WIDTH-1:0] shlVec;

  // In rotate mode the serial inputs are replaced by the opposite end bit.
  assign shrIn  = ROTATE ? Q[0] : SIR;
  assign shlIn  = ROTATE ? Q[WIDTH-1] : SIL;
  assign shrVec = {shrIn, Q[WIDTH-1:1]};
  assign shlVec = {Q[WIDTH-2:0], shlIn};

  for (genvar i = 0; i < WIDTH; i++) begin : gBit
    univ_reg_p_bit uBit (
      .clk      (CP),
      .clrn     (CLRN),
      .ce       (CE),
      .mode     (S),
      .loadBit  (D[i]),
      .shrBit   (shrVec[i]),
      .shlBit   (shlVec[i]),
      .resetBit (RESET_VALUE[i]),
      .q        (Q[i])
    );
  end

  assign QN   = ~Q;
  assign ZERO = (Q == {WIDTH{1'b0}});

  // Shift-out bits capture the end bit leaving the register on each shift.
  always_ff @(posedge CP) begin
    if (!CLRN) begin
      SOR <= 1'b0;
      SOL <= 1'b0;
    end else if (CE && (S == SHR)) begin
      SOR <= Q[0];
      SOL <= SOL;
    end else if (CE && (S == SHL)) begin
      SOR <= SOR;
      SOL <= Q[WIDTH-1];
    end else begin
      SOR <= SOR;
      SOL <= SOL;
    end
  end

endmodule : univ_reg_p
